// File: rtl/clk_div_ctrl_if.sv
// Divisor configuration channel for clk_div_ctrl: valid/ready transfer of a new
// half-period plus the discard-error pulse returned by the controller.
interface clk_div_ctrl_if #(
    parameter int unsigned CNT_WIDTH = 16
);
    logic [CNT_WIDTH-1:0] cfg_div;
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic                 cfg_err;

    modport master (
        output cfg_div,
        output cfg_valid,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_div,
        input  cfg_valid,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/clk_div_ctrl.sv
// Run/stop and divisor controller for a counter-based clock divider. New divisors
// are only applied at full-period boundaries so new_clk never emits a runt pulse.
module clk_div_ctrl #(
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned DEFAULT_DIV = 2604
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    clk_div_ctrl_if.slave        cfg,
    output logic [CNT_WIDTH-1:0] cur_div,
    output logic                 swap,
    output logic                 active,
    output logic                 tick,
    output logic                 new_clk
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StStop
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] cur_div_q, cur_div_d;
    logic [CNT_WIDTH-1:0] pend_div_q, pend_div_d;
    logic                 pend_vld_q, pend_vld_d;
    logic                 new_clk_q, new_clk_d;
    logic                 tick_q, tick_d;
    logic                 swap_q, swap_d;
    logic                 cfg_err_q, cfg_err_d;

    logic [CNT_WIDTH-1:0] div_last;
    logic                 terminal;
    logic                 boundary;
    logic                 accept;
    logic                 apply_pend;

    assign div_last = cur_div_q - CNT_WIDTH'(1);
    assign terminal = (state_q != StIdle) && (cnt_q == div_last);
    // A full period ends only on the falling toggle of new_clk.
    assign boundary = terminal && new_clk_q;
    assign accept   = cfg.cfg_valid && !pend_vld_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_div_d  = cur_div_q;
        pend_div_d = pend_div_q;
        pend_vld_d = pend_vld_q;
        new_clk_d  = new_clk_q;
        tick_d     = 1'b0;
        swap_d     = 1'b0;
        cfg_err_d  = 1'b0;
        apply_pend = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d      = '0;
                new_clk_d  = 1'b0;
                apply_pend = pend_vld_q;
                if (run) begin
                    state_d = StRun;
                end
            end
            StRun, StStop: begin
                if (terminal) begin
                    cnt_d     = '0;
                    new_clk_d = ~new_clk_q;
                    tick_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
                if (boundary) begin
                    apply_pend = pend_vld_q;
                    state_d    = run ? StRun : StIdle;
                end else begin
                    state_d = run ? StRun : StStop;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (apply_pend) begin
            cur_div_d  = pend_div_q;
            pend_vld_d = 1'b0;
            swap_d     = 1'b1;
        end

        // accept cannot coincide with apply_pend: both need opposite pend_vld_q.
        if (accept) begin
            if (cfg.cfg_div == '0) begin
                cfg_err_d = 1'b1;
            end else begin
                pend_div_d = cfg.cfg_div;
                pend_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            cur_div_q  <= CNT_WIDTH'(DEFAULT_DIV);
            pend_div_q <= '0;
            pend_vld_q <= 1'b0;
            new_clk_q  <= 1'b0;
            tick_q     <= 1'b0;
            swap_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_div_q  <= cur_div_d;
            pend_div_q <= pend_div_d;
            pend_vld_q <= pend_vld_d;
            new_clk_q  <= new_clk_d;
            tick_q     <= tick_d;
            swap_q     <= swap_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign cfg.cfg_ready = !pend_vld_q;
    assign cfg.cfg_err   = cfg_err_q;
    assign cur_div       = cur_div_q;
    assign swap          = swap_q;
    assign active        = (state_q != StIdle);
    assign tick          = tick_q;
    assign new_clk       = new_clk_q;

endmodule
